// File: rtl/dmem_responder_pkg.sv
// Shared funct3 codes, FSM states and access-decode helpers
// for the data-memory responder.
package dmem_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Misalignment or illegal funct3 for the given direction.
  function automatic logic acc_err(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic e;
    e = 1'b0;
    if (we && f3[2]) begin
      e = 1'b1;
    end else begin
      case (f3[1:0])
        2'b00:   e = 1'b0;
        2'b01:   e = lo[0];
        2'b10:   e = f3[2] | (lo != 2'b00);
        default: e = 1'b1;
      endcase
    end
    return e;
  endfunction

  function automatic logic [3:0] lane_mask(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic [3:0] m;
    m = 4'b0000;
    case (f3[1:0])
      2'b00:   m = 4'(4'b0001 << lo);
      2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_responder_bank.sv
// One byte lane of data memory: single port, synchronous
// write and registered read, contents never reset.
module dmem_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with fixed access latency,
// byte-lane stores and sign/zero-extending loads.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_width_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic DIRECT = (WAIT_CYCLES == 0);

  state_e        state;
  logic [3:0]    cnt;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    width_q;
  logic          we_q;
  logic          err_q;

  logic          accept;
  logic          req_err;
  logic          fire_now;
  logic          fire;

  assign accept  = req_valid_i & req_ready_o;
  assign req_err =
    acc_err(req_we_i, req_width_i, req_addr_i[1:0]) |
    ({2'b00, req_addr_i[31:2]} >= 32'(DEPTH_WORDS));

  // With no wait cycles the array is hit on the accept edge,
  // before the capture registers hold the request.
  assign fire_now = accept & DIRECT & ~rst_i;
  assign fire = fire_now |
    ((state == ST_WAIT) & (cnt == 4'd0) & ~rst_i);

  logic          m_we;
  logic          m_err;
  logic [2:0]    m_width;
  logic [1:0]    m_lo;
  logic [AW-1:0] m_idx;
  logic [31:0]   m_wdata;
  logic [3:0]    lane_we;

  assign m_we    = fire_now ? req_we_i : we_q;
  assign m_err   = fire_now ? req_err : err_q;
  assign m_width = fire_now ? req_width_i : width_q;
  assign m_lo    = fire_now ? req_addr_i[1:0] : addr_q[1:0];
  assign m_idx   = fire_now ? req_addr_i[AW+1:2]
                            : addr_q[AW+1:2];
  assign m_wdata = fire_now ? req_wdata_i : wdata_q;

  assign lane_we = (fire & m_we & ~m_err)
                 ? lane_mask(m_width, m_lo) : 4'b0000;

  logic [31:0] rd_word;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] wb;
    assign wb = m_width[1] ? m_wdata[8*i +: 8]
              : m_width[0] ? m_wdata[8*(i%2) +: 8]
              : m_wdata[7:0];

    dmem_bank #(
      .DEPTH (DEPTH_WORDS)
    ) u_bank (
      .clk_i (clk_i),
      .en    (fire),
      .we    (lane_we[i]),
      .addr  (m_idx),
      .wdata (wb),
      .rdata (rd_word[8*i +: 8])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      width_q     <= 3'd0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q      <= req_addr_i[AW+1:0];
            wdata_q     <= req_wdata_i;
            width_q     <= req_width_i;
            we_q        <= req_we_i;
            err_q       <= req_err;
            req_ready_o <= 1'b0;
            if (DIRECT) begin
              state       <= ST_RESP;
              rsp_valid_o <= 1'b1;
            end else begin
              state <= ST_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state       <= ST_RESP;
            rsp_valid_o <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state       <= ST_IDLE;
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          rsp_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] fmt;

  assign bsel = rd_word[8*addr_q[1:0] +: 8];
  assign hsel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    fmt = 32'd0;
    case (width_q)
      F3_LB:   fmt = {{24{bsel[7]}}, bsel};
      F3_LBU:  fmt = {24'd0, bsel};
      F3_LH:   fmt = {{16{hsel[15]}}, hsel};
      F3_LHU:  fmt = {16'd0, hsel};
      F3_LW:   fmt = rd_word;
      default: fmt = 32'd0;
    endcase
  end

  assign rsp_err_o   = rsp_valid_o & err_q;
  assign rsp_rdata_o = (rsp_valid_o & ~we_q & ~err_q)
                     ? fmt : 32'd0;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, is the number of 32-bit words in the memory array and SHALL be a power of two.
REQ-002 Parameter WAIT_CYCLES, default 1, is the number of access-latency cycles between request acceptance and response (legal range 0..15).
REQ-003 Port clk_i  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_i  input  1  is the reset, asynchronous and active-high.
REQ-005 Port req_valid_i  input  1  indicates that a request is presented.
REQ-006 Port req_ready_o  output  1  indicates that a request can be accepted this cycle.
REQ-007 Port req_we_i  input  1  selects the access type: 1 = store, 0 = load.
REQ-008 Port req_addr_i  input  32  is the byte address of the access.
REQ-009 Port req_wdata_i  input  32  is the store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-010 Port req_width_i  input  3  is funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010.
REQ-011 Port rsp_valid_o  output  1  indicates that a response is presented.
REQ-012 Port rsp_ready_i  input  1  indicates that the requester accepts the response.
REQ-013 Port rsp_rdata_o  output  32  is the formatted load data; it SHALL be 0 for stores and for errors.
REQ-014 Port rsp_err_o  output  1  flags a misaligned, illegal-width or out-of-range access.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-016 req_ready_o SHALL be 1 only in IDLE; a request is accepted on req_valid_i & req_ready_o, and its address, data, width and we are captured into internal registers.
REQ-017 On acceptance, the FSM SHALL go IDLE->WAIT with the wait counter loaded to WAIT_CYCLES-1; if WAIT_CYCLES=0 it SHALL go IDLE->RESP directly.
REQ-018 In WAIT, the counter SHALL decrement each cycle; when the counter equals 0, the FSM SHALL go WAIT->RESP.
REQ-019 The memory access (read sample and write commit) SHALL occur on the edge that enters RESP, so response latency equals WAIT_CYCLES+1 cycles after acceptance.
REQ-020 In RESP, rsp_valid_o SHALL be 1, and rsp_rdata_o and rsp_err_o SHALL hold stable until rsp_ready_i=1.
REQ-021 On rsp_valid_o & rsp_ready_i the FSM SHALL return to IDLE, so back-to-back requests are spaced by at least one IDLE cycle.
REQ-022 Misaligned accesses SHALL be flagged as errors: LH, LHU or SH with addr[0]=1; LW or SW with addr[1:0]!=00.
REQ-023 Illegal widths SHALL be flagged as errors: for loads, funct3 in {011,110,111}; for stores, funct3 >= 011.
REQ-024 Out-of-range addresses SHALL be flagged as errors: addr[31:2] >= DEPTH_WORDS.
REQ-025 An access flagged as an error SHALL write no byte, SHALL return rdata=0 with err=1, and SHALL still complete the handshake.
REQ-026 Stores SHALL write byte lanes as follows: SB writes lane addr[1:0] with wdata[7:0]; SH writes lanes {1,0} or {3,2} (selected by addr[1]) with wdata[15:0]; SW writes all four lanes.
REQ-027 Loads SHALL format data as follows: LB/LH sign-extend the selected byte/halfword, LBU/LHU zero-extend it, and LW returns {lane3,lane2,lane1,lane0}.
REQ-028 A load issued after a store to the same word SHALL return the updated data (no stale read).

Reset
REQ-029 On rst_i=1, the FSM SHALL go to IDLE, the counter and captured registers SHALL clear to 0, and the outputs SHALL be: req_ready_o=1 after release, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
REQ-030 Reset asserted in WAIT SHALL abort the access with no memory write; reset asserted in RESP SHALL drop the response.
REQ-031 Memory array contents SHALL NOT be reset.

Structure
REQ-032 The funct3 constants (LB..LHU, SB..SW) and the FSM state encodings SHALL live in the shared package used by mem_stage.
REQ-033 One sub-module, dmem_bank (byte-wide, single-port, synchronous write, DEPTH_WORDS deep), SHALL be instantiated four times, once per lane.

Verification
REQ-034 SW 0x11223344 @0x10, then LW @0x10 (WAIT_CYCLES=1) -> rdata=0x11223344, err=0, rsp_valid 2 cycles after acceptance.
REQ-035 SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80223344.
REQ-036 SH 0xBEEF @0x12, then LH @0x12 -> 0xFFFFBEEF; LHU @0x12 -> 0x0000BEEF; LH @0x11 -> err=1, rdata=0.
REQ-037 SW 0xDEADBEEF @0x16 -> err=1; LW @0x14 afterwards -> word unchanged; SW @(DEPTH_WORDS*4) -> err=1.
REQ-038 rsp_ready_i held 0 for 5 cycles in RESP -> rsp_valid_o stays 1 with stable data; req_ready_o stays 0 throughout.
REQ-039 SW 0xCAFEF00D @0x20 with rst_i pulsed during WAIT (WAIT_CYCLES=3) -> no response; a subsequent LW @0x20 returns the prior contents.
